// File: rtl/lsu.sv
// Load/store unit: turns one decoded memory request into a single-port 64-bit
// bus transaction (req/gnt/rvalid) and returns aligned, extended load data.
module lsu #(
  parameter int XLEN = 64
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Fields captured at accept; only needed to finish the access, so no reset.
  logic       st_q;
  logic [2:0] f3_q;
  logic [2:0] off_q;

  logic accept;
  logic acc_store;
  logic acc_load;
  logic acc_mis;

  // Byte-lane strobes: n = 1<<size bytes starting at lane off.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [2:0] off);
    logic [3:0]  n;
    logic [15:0] m;
    n = 4'd1 << size;
    m = (16'd1 << n) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

  // Shift the addressed bytes down to bit 0, keep 8n bits, then extend.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      off,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] raw;
    logic            uns;
    raw = word >> {off, 3'b000};
    uns = f3[2];
    case (f3[1:0])
      2'd0:    load_extend = uns ? {{(XLEN-8){1'b0}},  raw[7:0]}
                                 : {{(XLEN-8){raw[7]}},  raw[7:0]};
      2'd1:    load_extend = uns ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                 : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'd2:    load_extend = uns ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                 : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: load_extend = raw;
    endcase
  endfunction

  // Request decode in IDLE: store takes priority over load.
  always_comb begin
    accept    = (state_q == IDLE) && req_valid;
    acc_store = req_is_store;
    acc_load  = req_is_load && !req_is_store;
    case (req_funct3[1:0])
      2'd1:    acc_mis = req_addr[0];
      2'd2:    acc_mis = |req_addr[1:0];
      2'd3:    acc_mis = |req_addr[2:0];
      default: acc_mis = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; rvalid only counts while waiting for read data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (acc_mis || !(acc_store || acc_load)) state_d = RESP;
          else                                     state_d = REQ;
        end
      end
      REQ:     if (dmem_gnt) state_d = st_q ? RESP : WAIT;
      WAIT:    if (dmem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the pipeline may hand over a request only when idle.
  always_comb begin
    req_ready = (state_q == IDLE);
  end

  // Capture request fields needed after accept.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      st_q  <= acc_store;
      f3_q  <= req_funct3;
      off_q <= req_addr[2:0];
    end
  end

  // Registered bus outputs: loaded at accept, held stable through REQ.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
    end else begin
      dmem_req <= (state_d == REQ);
      if (accept && (state_d == REQ)) begin
        dmem_we    <= acc_store;
        dmem_addr  <= {req_addr[XLEN-1:3], 3'b000};
        dmem_wdata <= acc_store ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;
        dmem_wmask <= acc_store ? lane_mask(req_funct3[1:0], req_addr[2:0]) : 8'h00;
      end
    end
  end

  // Registered response: one-cycle valid pulse, data and flag held until the next one.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid <= (state_d == RESP);
      if (state_d == RESP) begin
        case (state_q)
          IDLE: begin
            resp_rdata      <= '0;
            resp_misaligned <= acc_mis;
          end
          WAIT: begin
            resp_rdata      <= load_extend(dmem_rdata, off_q, f3_q);
            resp_misaligned <= 1'b0;
          end
          default: begin
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: stores, loads with extension, misalignment,
// no-op, back-to-back accept, grant stall and reset during an access.
module tb_lsu;

  logic        sys_clk;
  logic        sys_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  lsu #(.XLEN(64)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_load     (req_is_load),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wmask      (dmem_wmask),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present a request for one cycle (caller is in the accept cycle).
  task automatic drive_req(input logic st, input logic ld, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_is_load  = ld;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    tick();
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_is_load  = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
    n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_we: got %b want 0", dmem_we); end
    n_checks++; if (dmem_wmask !== 8'h00) begin n_fail++; $display("FAIL rst_wmask: got %h want 00", dmem_wmask); end
    n_checks++; if (dmem_addr !== 64'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", dmem_addr); end
    n_checks++; if (dmem_wdata !== 64'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", dmem_wdata); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", resp_misaligned); end
  endtask

  task automatic test_store_d();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sd_ready_t0: got %b want 1", req_ready); end
    drive_req(1'b1, 1'b0, 3'b011, 64'h1000, 64'h1122334455667788);
    // T1: request on the bus
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL sd_req: got %b want 1", dmem_req); end
    n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sd_we: got %b want 1", dmem_we); end
    n_checks++; if (dmem_addr !== 64'h1000) begin n_fail++; $display("FAIL sd_addr: got %h want 1000", dmem_addr); end
    n_checks++; if (dmem_wmask !== 8'hFF) begin n_fail++; $display("FAIL sd_wmask: got %h want ff", dmem_wmask); end
    n_checks++; if (dmem_wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL sd_wdata: got %h want 1122334455667788", dmem_wdata); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sd_ready_t1: got %b want 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sd_resp_t1: got %b want 0", resp_valid); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    // T2: completion
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sd_resp_t2: got %b want 1", resp_valid); end
    n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL sd_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL sd_req_t2: got %b want 0", dmem_req); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sd_ready_t2: got %b want 0", req_ready); end
    tick();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sd_resp_t3: got %b want 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sd_ready_t3: got %b want 1", req_ready); end
  endtask

  task automatic test_store_b();
    drive_req(1'b1, 1'b0, 3'b000, 64'h1005, 64'h00000000000000AB);
    n_checks++; if (dmem_wmask !== 8'h20) begin n_fail++; $display("FAIL sb_wmask: got %h want 20", dmem_wmask); end
    n_checks++; if (dmem_wdata !== 64'h0000AB0000000000) begin n_fail++; $display("FAIL sb_wdata: got %h want 0000ab0000000000", dmem_wdata); end
    n_checks++; if (dmem_addr !== 64'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 1000", dmem_addr); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sb_resp: got %b want 1", resp_valid); end
    tick();
  endtask

  // Zero-wait load: gnt in T1, rvalid in T2, response in T3.
  task automatic load_zero_wait(input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] word, output logic [63:0] data,
                                output logic v_t2, output logic v_t3,
                                output logic we_t1, output logic [7:0] mask_t1);
    drive_req(1'b0, 1'b1, f3, a, 64'hFFFF_FFFF_FFFF_FFFF);
    we_t1   = dmem_we;
    mask_t1 = dmem_wmask;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    v_t2        = resp_valid;
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'h0;
    v_t3 = resp_valid;
    data = resp_rdata;
    tick();
  endtask

  task automatic test_load_byte();
    logic [63:0] d;
    logic v2, v3, we;
    logic [7:0] m;
    load_zero_wait(3'b000, 64'h2003, 64'h0000000080000000, d, v2, v3, we, m);
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", we); end
    n_checks++; if (m !== 8'h00) begin n_fail++; $display("FAIL lb_wmask: got %h want 00", m); end
    n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL lb_resp_t2: got %b want 0", v2); end
    n_checks++; if (v3 !== 1'b1) begin n_fail++; $display("FAIL lb_resp_t3: got %b want 1", v3); end
    n_checks++; if (d !== 64'hFFFFFFFFFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffffffffffff80", d); end
    load_zero_wait(3'b100, 64'h2003, 64'h0000000080000000, d, v2, v3, we, m);
    n_checks++; if (d !== 64'h0000000000000080) begin n_fail++; $display("FAIL lbu_data: got %h want 80", d); end
  endtask

  task automatic test_load_word();
    logic [63:0] d;
    logic v2, v3, we;
    logic [7:0] m;
    load_zero_wait(3'b110, 64'h2004, 64'hDEADBEEF00000000, d, v2, v3, we, m);
    n_checks++; if (d !== 64'h00000000DEADBEEF) begin n_fail++; $display("FAIL lwu_data: got %h want 00000000deadbeef", d); end
    load_zero_wait(3'b010, 64'h2004, 64'hDEADBEEF00000000, d, v2, v3, we, m);
    n_checks++; if (d !== 64'hFFFFFFFFDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want ffffffffdeadbeef", d); end
    load_zero_wait(3'b001, 64'h2006, 64'h8001000000000000, d, v2, v3, we, m);
    n_checks++; if (d !== 64'hFFFFFFFFFFFF8001) begin n_fail++; $display("FAIL lh_data: got %h want ffffffffffff8001", d); end
    load_zero_wait(3'b111, 64'h2008, 64'h8877665544332211, d, v2, v3, we, m);
    n_checks++; if (d !== 64'h8877665544332211) begin n_fail++; $display("FAIL ld111_data: got %h want 8877665544332211", d); end
  endtask

  task automatic test_misaligned();
    drive_req(1'b0, 1'b1, 3'b010, 64'h2002, 64'h0);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mis_resp: got %b want 1", resp_valid); end
    n_checks++; if (resp_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", resp_misaligned); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_dmem_req: got %b want 0", dmem_req); end
    tick();
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_dmem_req2: got %b want 0", dmem_req); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mis_resp2: got %b want 0", resp_valid); end
    n_checks++; if (resp_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_hold: got %b want 1", resp_misaligned); end
  endtask

  // No-op completes in T1; a store is then accepted in the very next cycle.
  task automatic test_back_to_back();
    drive_req(1'b0, 1'b0, 3'b011, 64'h5000, 64'h0);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL nop_resp: got %b want 1", resp_valid); end
    n_checks++; if (resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL nop_mis: got %b want 0", resp_misaligned); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL nop_dmem_req: got %b want 0", dmem_req); end
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    drive_req(1'b1, 1'b0, 3'b001, 64'h4006, 64'h000000000000BEEF);
    n_checks++; if (dmem_wmask !== 8'hC0) begin n_fail++; $display("FAIL sh_wmask: got %h want c0", dmem_wmask); end
    n_checks++; if (dmem_wdata !== 64'hBEEF000000000000) begin n_fail++; $display("FAIL sh_wdata: got %h want beef000000000000", dmem_wdata); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sh_resp: got %b want 1", resp_valid); end
    tick();
  endtask

  // Grant withheld T1..T3, given in T4 with a stray rvalid; real rvalid in T5.
  task automatic test_gnt_stall();
    drive_req(1'b0, 1'b1, 3'b011, 64'h3008, 64'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 1", i, dmem_req); end
      n_checks++; if (dmem_addr !== 64'h3008) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 3008", i, dmem_addr); end
      tick();
    end
    n_checks++; if (dmem_addr !== 64'h3008) begin n_fail++; $display("FAIL stall_addr_t4: got %h want 3008", dmem_addr); end
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hBADBADBADBADBAD0;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_resp_t5: got %b want 0", resp_valid); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_t5: got %b want 0", dmem_req); end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h0123456789ABCDEF;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'h0;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resp_t6: got %b want 1", resp_valid); end
    n_checks++; if (resp_rdata !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL stall_data: got %h want 0123456789abcdef", resp_rdata); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive_req(1'b0, 1'b1, 3'b010, 64'h2008, 64'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    sys_rst  = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rw_ready_wait: got %b want 0", req_ready); end
    tick();
    sys_rst     = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h0000000012345678;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b want 1", req_ready); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rw_dmem_req: got %b want 0", dmem_req); end
    n_checks++; if (dmem_addr !== 64'h0) begin n_fail++; $display("FAIL rw_addr: got %h want 0", dmem_addr); end
    n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL rw_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_resp: got %b want 0", resp_valid); end
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'h0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_resp2: got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL rw_rdata2: got %h want 0", resp_rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready2: got %b want 1", req_ready); end
    tick();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_resp3: got %b want 0", resp_valid); end
  endtask

  initial begin
    sys_rst      = 1'b0;
    req_valid    = 1'b0;
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 64'h0;
    req_wdata    = 64'h0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = 64'h0;
    test_reset();
    test_store_d();
    test_store_b();
    test_load_byte();
    test_load_word();
    test_misaligned();
    test_back_to_back();
    test_gnt_stall();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the five-stage RV64 pipeline: consumes the memory-access request produced by decode/execute, namely store enable, funct3 width code, ALU-computed address and rs2 store data. It drives a single-port, 64-bit data-memory bus with a req/gnt/rvalid handshake. It returns load data to writeback, already byte-aligned and sign/zero-extended, and holds the pipeline via `req_ready` while an access is in flight.

## Interface
- `XLEN`, 64, data and address width; only 64 is supported.
- `sys_clk`  in  1  clock.
- `sys_rst`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  memory request present.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_is_load`  in  1  load request.
- `req_is_store`  in  1  store request; wins if both set.
- `req_funct3`  in  3  [1:0] size (0=B,1=H,2=W,3=D), [2]=unsigned load.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, LSB-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  XLEN  extended load data (0 for stores).
- `resp_misaligned`  out  1  valid with `resp_valid`; access not performed.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1=write.
- `dmem_addr`  out  XLEN  `req_addr` with [2:0] forced to 0.
- `dmem_wdata`  out  XLEN  lane-shifted store data.
- `dmem_wmask`  out  8  byte-lane write strobes.
- `dmem_gnt`  in  1  bus accepted request this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  XLEN  aligned 64-bit read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE:** `req_ready`=1. On `req_valid`, latch all request fields.
  - Misaligned (addr[0] for H, addr[1:0] for W, addr[2:0] for D) -> RESP with misaligned=1. No bus access.
  - Neither load nor store -> RESP with rdata=0.
  - Otherwise -> REQ.
- **REQ:** `dmem_req`=1 and all `dmem_*` held stable until `dmem_gnt`.
  - On gnt, a store goes to RESP and a load goes to WAIT.
- **WAIT:** on `dmem_rvalid`, capture the extended data -> RESP. `dmem_rvalid` is ignored in every other state.
- **RESP:** `resp_valid`=1 for exactly one cycle -> IDLE. There is no backpressure.
- Lane arithmetic, with off = addr[2:0] and n = 1<<size:
  - `dmem_wmask` = ((1<<n)-1)<<off, truncated to 8 bits.
  - `dmem_wdata` = `req_wdata`<<(8*off).
- Load extraction:
  - raw = `dmem_rdata`>>(8*off).
  - Keep the low 8n bits.
  - funct3[2]=0 sign-extends from bit 8n-1; funct3[2]=1 zero-extends.
  - funct3=3'b111 behaves as ld.
- `dmem_we`=0 and `dmem_wmask`=0 for loads.
- `resp_rdata` and `resp_misaligned` hold their values until the next `resp_valid`.

## Timing
- Reset (sys_rst=0 at an edge): state=IDLE.
  - `req_ready`=1.
  - `dmem_req`=0, `dmem_we`=0, `dmem_wmask`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_misaligned`=0.
- Reset mid-operation aborts the access. `dmem_req` drops at that edge, and a later stray `dmem_rvalid` is ignored.
- `dmem_*` outputs and `resp_*` are registered. `req_ready` is decoded from state.
- Accept at cycle T0 with zero-wait memory (gnt in the first REQ cycle, rvalid one cycle after gnt):
  - Store: REQ T1, `resp_valid` T2.
  - Load: REQ T1, WAIT T2 (rvalid), `resp_valid` T3.
  - Misaligned or no-op: `resp_valid` T1.
- Each cycle of gnt stall or rvalid delay adds exactly one cycle.
- `req_ready`=0 from T1 through the `resp_valid` cycle. A new request can be accepted in the cycle after `resp_valid`.
- The earliest counted `dmem_rvalid` is the cycle after gnt. An rvalid coincident with gnt is ignored.

## Test plan
- sd of 0x1122334455667788 to 0x1000 (gnt immediate):
  - `dmem_addr`=0x1000, wmask=0xFF, wdata unchanged, we=1.
  - `resp_valid` two cycles after accept, rdata=0.
- sb of 0xAB to 0x1005:
  - wmask=0x20, wdata=0x0000AB0000000000, `dmem_addr`=0x1000.
- lb from 0x2003 with rdata=0x00000000_80000000:
  - `resp_rdata`=0xFFFFFFFFFFFFFF80, three cycles after accept.
  - Same access as lbu -> 0x80.
- lwu from 0x2004 with rdata=0xDEADBEEF_00000000:
  - `resp_rdata`=0x00000000DEADBEEF.
  - Same access as lw -> 0xFFFFFFFFDEADBEEF.
- lw at 0x2002:
  - `resp_valid` one cycle after accept, misaligned=1, `dmem_req` never asserted.
- ld with gnt withheld for 3 cycles:
  - `dmem_addr` stable throughout.
  - `resp_valid` at T6 with the correct data.
- Reset asserted in WAIT, then rvalid pulsed:
  - All outputs at reset values, no `resp_valid`, `req_ready`=1.
